// File: rtl/seg_scan_display.sv
// seg_scan_display: scanned active-low 7-segment driver with a self-timed LED countdown bar.
// Each digit slot lasts SCAN_DIV clocks. The frame inputs are snapshotted when digit 0 is loaded,
// so a frame never mixes old and new inputs. The countdown is an IDLE/RUN sequencer with a
// start/abort/done handshake.
// Optional feature: define DISP_BLINK_EN to blank flagged digits on a BLINK_FRAMES-frame blink phase.
module seg_scan_display #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned LED_NUM      = 10,
  parameter int unsigned STEP_W       = 24,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [5*NUM_DIGITS-1:0] glyph,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    cd_start,
  input  logic                    cd_abort,
  input  logic [STEP_W-1:0]       cd_step,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [7:0]              SEG,
  output logic [LED_NUM-1:0]      LED,
  output logic                    cd_busy,
  output logic                    cd_done
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  typedef enum logic {S_IDLE, S_RUN} cd_state_t;

  // Glyph code to {a..g}, active low
  function automatic logic [6:0] f_decode(input logic [4:0] code);
    case (code)
      5'd0:    f_decode = 7'b0000001;
      5'd1:    f_decode = 7'b1001111;
      5'd2:    f_decode = 7'b0010010;
      5'd3:    f_decode = 7'b0000110;
      5'd4:    f_decode = 7'b1001100;
      5'd5:    f_decode = 7'b0100100;
      5'd6:    f_decode = 7'b0100000;
      5'd7:    f_decode = 7'b0001111;
      5'd8:    f_decode = 7'b0000000;
      5'd9:    f_decode = 7'b0000100;
      5'd10:   f_decode = 7'b0001000;
      5'd11:   f_decode = 7'b1100000;
      5'd12:   f_decode = 7'b0110001;
      5'd13:   f_decode = 7'b1000010;
      5'd14:   f_decode = 7'b0110000;
      5'd15:   f_decode = 7'b0111000;
      5'd16:   f_decode = 7'b1001000;
      5'd17:   f_decode = 7'b1110001;
      5'd18:   f_decode = 7'b1111010;
      5'd19:   f_decode = 7'b0011000;
      5'd20:   f_decode = 7'b1110111;
      5'd21:   f_decode = 7'b1111110;
      default: f_decode = 7'b1111111;
    endcase
  endfunction

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [5*NUM_DIGITS-1:0] r_glyph_s;
  logic [NUM_DIGITS-1:0]   r_en_s;
  logic [NUM_DIGITS-1:0]   r_dp_s;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [7:0]              r_seg;

  logic                    w_tick;
  logic                    w_load0;
  logic [5*NUM_DIGITS-1:0] w_glyph_src;
  logic [NUM_DIGITS-1:0]   w_en_src;
  logic [NUM_DIGITS-1:0]   w_dp_src;
  logic [4:0]              w_code;
  logic                    w_en_bit;
  logic                    w_dp_bit;
  logic                    w_blank;
  logic [NUM_DIGITS-1:0]   w_an_hot;

  assign w_tick  = (r_presc == PW'(SCAN_DIV - 1));
  // r_idx is the digit loaded into AN/SEG on the next tick
  assign w_load0 = (r_idx == '0);

  // Digit 0 takes live inputs; the rest of the frame reads the snapshot taken alongside it
  assign w_glyph_src = w_load0 ? glyph    : r_glyph_s;
  assign w_en_src    = w_load0 ? digit_en : r_en_s;
  assign w_dp_src    = w_load0 ? dp       : r_dp_s;

`ifdef DISP_BLINK_EN
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [NUM_DIGITS-1:0] r_blink_s;
  logic [FW-1:0]         r_frame;
  logic                  r_phase;
  logic [NUM_DIGITS-1:0] w_blink_src;
  logic                  w_wrap;

  assign w_blink_src = w_load0 ? blink : r_blink_s;
  assign w_wrap      = w_tick && (r_idx == IW'(NUM_DIGITS - 1));

  // Blink phase flips after every BLINK_FRAMES completed frames
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_blink_s <= '0;
      r_frame   <= '0;
      r_phase   <= 1'b0;
    end else begin
      if (w_tick && w_load0) r_blink_s <= blink;
      if (w_wrap) begin
        if (r_frame == FW'(BLINK_FRAMES - 1)) begin
          r_frame <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_frame <= r_frame + FW'(1);
        end
      end
    end
  end
`else
  logic w_unused_blink;
  assign w_unused_blink = (^blink) ^ (BLINK_FRAMES == 0);
`endif

  // Select the fields and the anode of the digit being loaded
  always_comb begin
    w_code   = '0;
    w_en_bit = 1'b0;
    w_dp_bit = 1'b0;
    w_blank  = 1'b0;
    w_an_hot = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_code   = w_glyph_src[5*i +: 5];
        w_en_bit = w_en_src[i];
        w_dp_bit = w_dp_src[i];
`ifdef DISP_BLINK_EN
        w_blank  = r_phase && w_blink_src[i];
`endif
        w_an_hot[NUM_DIGITS-1-i] = 1'b0;
      end
    end
  end

  // Slot prescaler and digit index
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Frame snapshot, captured on the tick that loads digit 0
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_glyph_s <= '0;
      r_en_s    <= '0;
      r_dp_s    <= '0;
    end else if (w_tick && w_load0) begin
      r_glyph_s <= glyph;
      r_en_s    <= digit_en;
      r_dp_s    <= dp;
    end
  end

  // Registered anode/segment outputs; a disabled or blanked digit keeps its slot with no anode lit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_an  <= '1;
      r_seg <= 8'hFF;
    end else if (w_tick) begin
      r_an  <= (w_en_bit && !w_blank) ? w_an_hot : '1;
      r_seg <= {f_decode(w_code), ~w_dp_bit};
    end
  end

  assign AN  = r_an;
  assign SEG = r_seg;

  cd_state_t          r_state;
  cd_state_t          w_state_n;
  logic [LED_NUM-1:0] r_led;
  logic [LED_NUM-1:0] w_led_n;
  logic [LED_NUM-1:0] w_led_shr;
  logic [STEP_W-1:0]  r_cnt;
  logic [STEP_W-1:0]  w_cnt_n;
  logic [STEP_W-1:0]  r_lim;
  logic [STEP_W-1:0]  w_lim_n;
  logic [STEP_W-1:0]  w_lim;
  logic               r_busy;
  logic               w_busy_n;
  logic               r_done;
  logic               w_done_n;

  // Terminal count for the step length presented now; a step of 0 behaves as 1
  assign w_lim     = (cd_step == '0) ? '0 : cd_step - STEP_W'(1);
  assign w_led_shr = r_led >> 1;

  // Countdown state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_led   <= '0;
      r_cnt   <= '0;
      r_lim   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_led   <= w_led_n;
      r_cnt   <= w_cnt_n;
      r_lim   <= w_lim_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  // Countdown next state; abort beats start, start beats the running count
  always_comb begin
    w_state_n = r_state;
    w_led_n   = r_led;
    w_cnt_n   = r_cnt;
    w_lim_n   = r_lim;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    if (cd_abort) begin
      w_state_n = S_IDLE;
      w_led_n   = '0;
      w_cnt_n   = '0;
      w_busy_n  = 1'b0;
    end else if (cd_start) begin
      w_state_n = S_RUN;
      w_led_n   = '1;
      w_cnt_n   = '0;
      w_lim_n   = w_lim;
      w_busy_n  = 1'b1;
    end else begin
      case (r_state)
        S_RUN: begin
          if (r_cnt == r_lim) begin
            w_cnt_n = '0;
            w_lim_n = w_lim;
            w_led_n = w_led_shr;
            if (w_led_shr == '0) begin
              w_state_n = S_IDLE;
              w_busy_n  = 1'b0;
              w_done_n  = 1'b1;
            end
          end else begin
            w_cnt_n = r_cnt + STEP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign LED     = r_led;
  assign cd_busy = r_busy;
  assign cd_done = r_done;

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Parametrised successor to the lock's display driver.
- Time-multiplexes NUM_DIGITS active-low 7-segment digits from per-digit glyph codes, using an internal scan prescaler. No separate scan clock.
- Owns the LED countdown bar as a self-timed sequencer with start/abort/done handshake, replacing the externally decoded COUNT_CLK thresholds.
- Sits between the lock FSM (supplies glyphs and countdown requests) and the board pins.

Parameters:
- NUM_DIGITS, 8, number of scanned digits (2..8).
- SCAN_DIV, 50000, CLK cycles per digit slot (>=2).
- LED_NUM, 10, countdown bar length.
- STEP_W, 24, width of cd_step.
- BLINK_FRAMES, 64, scan frames per blink half-period (used only with DISP_BLINK_EN).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- glyph  in  5*NUM_DIGITS  glyph code; digit i = glyph[5i+4:5i].
- digit_en  in  NUM_DIGITS  1 = digit i shown.
- dp  in  NUM_DIGITS  1 = decimal point lit on digit i.
- blink  in  NUM_DIGITS  1 = digit i blinks (ignored without DISP_BLINK_EN).
- cd_start  in  1  single-cycle pulse: begin countdown.
- cd_abort  in  1  single-cycle pulse: cancel countdown.
- cd_step  in  STEP_W  CLK cycles per LED step; 0 is treated as 1.
- AN  out  NUM_DIGITS  digit anodes, active low.
- SEG  out  8  {a,b,c,d,e,f,g,dp}, active low; SEG[7]=a, SEG[0]=dp.
- LED  out  LED_NUM  countdown bar.
- cd_busy  out  1  countdown running.
- cd_done  out  1  one-cycle pulse on natural expiry.

Behaviour:
- Reset (async, RST=1): AN all ones, SEG=8'hFF, LED=0, cd_busy=0, cd_done=0, prescaler=0, digit index=0, snapshot registers cleared, blink phase=0.
- Scan prescaler: counts 0..SCAN_DIV-1. A tick is asserted on the wrap; on each tick the index advances 0..NUM_DIGITS-1 and wraps.
- Digit i drives AN[NUM_DIGITS-1-i] low; digit 0 is the leftmost anode (MSB).
- AN/SEG are registered and change in the cycle after the tick. Exactly one AN bit is low per slot, or none if the digit is disabled or blanked. The slot length is unchanged, so duty stays uniform.
- Tearing-free display: glyph, digit_en, dp and blink are snapshotted on the tick that enters index 0. Mid-frame input changes appear from the next frame only.
- Glyph decode, SEG[7:1] values:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - 10 A=0001000, 11 b=1100000, 12 C=0110001, 13 d=1000010, 14 E=0110000, 15 F=0111000.
  - 16 H=1001000, 17 L=1110001, 18 r=1111010, 19 P=0011000, 20 '_'=1110111, 21 '-'=1111110.
  - 22..31 blank=1111111.
- SEG[0] = ~dp[i], for every glyph including blank.
- Countdown states: IDLE, RUN.
  - IDLE + cd_start: LED all ones next cycle, step counter=0, cd_busy=1, go to RUN.
  - RUN: step counter counts to max(cd_step,1)-1, then LED <= LED>>1 (MSB clears first) and the counter restarts.
  - Expiry: the shift that makes LED zero also raises cd_done for that one cycle and returns the block to IDLE with cd_busy=0. Total RUN time = LED_NUM*max(cd_step,1) cycles.
  - cd_start during RUN restarts: LED all ones, counter 0, no cd_done.
  - cd_abort: LED=0, cd_busy=0 next cycle, no cd_done. Abort wins when it coincides with start.
  - cd_step is sampled continuously; a change takes effect at the next counter restart.
- The scan and countdown logic are independent; reset mid-operation returns both to reset values immediately.

Optional Feature:
- Macro: DISP_BLINK_EN.
- Defined: a blink phase toggles every BLINK_FRAMES completed frames (index wrap to 0). While phase=1, digits with blink snapshot=1 are blanked (AN bit held high for the slot).
- Undefined: the blink port is ignored, there is no phase register, and digits never blank except through digit_en.

Test Plan:
- Reset release, SCAN_DIV=4, NUM_DIGITS=8, all enabled, glyph all 8 -> AN walks 01111111, 10111111, ... 11111110, each held 4 cycles; SEG=00000001 on every slot.
- Glyph {16,14,17,17,0} on digits 0..4, dp[1]=1, digit_en=8'h1F -> digit 0 SEG=10010001, digit 1 SEG=01100000, digits 5..7 AN all ones.
- Change glyph[0] while index=3 -> old value persists until the next index-0 tick, then the new value shows.
- cd_step=3, cd_start -> LED=3FF, then 1FF after 3 cycles, ..., then 000 with a one-cycle cd_done at cycle 30; cd_busy falls with it.
- cd_start at step 5 of a run, then cd_abort with cd_start in the same cycle -> the restart reloads 3FF; the abort clears LED to 0 with no cd_done.
- DISP_BLINK_EN, BLINK_FRAMES=2, blink[2]=1 -> digit 2 AN stays high for frames 2-3, visible in frames 0-1 and 4-5.
